// File: rtl/cpu_wrapper_v3_pkg.sv
// Shared ISA constants, decoded-op kinds and inter-stage bundles
// for the 8-bit five-stage cpu_wrapper_v3 core.
package cpu_wrapper_v3_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_IO  = 4'h7;
  localparam logic [3:0] OP_MEM = 4'hC;

  localparam logic [1:0] IO_OUT  = 2'b10;
  localparam logic [1:0] IO_IN   = 2'b11;
  localparam logic [1:0] MEM_LDM = 2'b00;
  localparam logic [1:0] MEM_LDD = 2'b01;
  localparam logic [1:0] MEM_STD = 2'b10;

  localparam logic [7:0] NOP_INSTR = 8'h00;
  localparam logic [7:0] SP_RESET  = 8'hFF;

  typedef enum logic [3:0] {
    K_NOP, K_MOV, K_ADD, K_SUB, K_AND, K_OR,
    K_OUT, K_IN, K_LDM, K_LDD, K_STD
  } kind_e;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] imm;
  } if_id_t;

  typedef struct packed {
    kind_e      kind;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
  } id_ex_t;

  typedef struct packed {
    kind_e      kind;
    logic [1:0] rd;
    logic [7:0] res;
    logic [7:0] addr;
  } ex_mem_t;

  typedef struct packed {
    logic       wen;
    logic [1:0] rd;
    logic [7:0] res;
  } mem_wb_t;

  function automatic kind_e decode(input logic [7:0] i);
    kind_e k;
    k = K_NOP;
    unique case (1'b1)
      i[7:4] == OP_MOV: k = K_MOV;
      i[7:4] == OP_ADD: k = K_ADD;
      i[7:4] == OP_SUB: k = K_SUB;
      i[7:4] == OP_AND: k = K_AND;
      i[7:4] == OP_OR:  k = K_OR;
      i[7:4] == OP_IO && i[3:2] == IO_OUT:
        k = K_OUT;
      i[7:4] == OP_IO && i[3:2] == IO_IN:
        k = K_IN;
      i[7:4] == OP_MEM && i[3:2] == MEM_LDM:
        k = K_LDM;
      i[7:4] == OP_MEM && i[3:2] == MEM_LDD:
        k = K_LDD;
      i[7:4] == OP_MEM && i[3:2] == MEM_STD:
        k = K_STD;
      default: k = K_NOP;
    endcase
    return k;
  endfunction

  function automatic logic writes_reg(input kind_e k);
    return k inside {K_MOV, K_ADD, K_SUB, K_AND,
                     K_OR, K_IN, K_LDM, K_LDD};
  endfunction

  function automatic logic uses_ra(input kind_e k);
    return k inside {K_ADD, K_SUB, K_AND, K_OR};
  endfunction

  function automatic logic uses_rb(input kind_e k);
    return k inside {K_MOV, K_ADD, K_SUB, K_AND,
                     K_OR, K_OUT, K_STD};
  endfunction

  // Results produced only in MEM; a direct consumer must wait.
  function automatic logic is_load(input kind_e k);
    return k inside {K_LDD, K_IN};
  endfunction

  function automatic logic [1:0] dest_reg(
    input kind_e      k,
    input logic [1:0] ra,
    input logic [1:0] rb
  );
    return (k inside {K_IN, K_LDM, K_LDD}) ? rb : ra;
  endfunction

endpackage

// File: rtl/cpu_wrapper_v3_register_file.sv
// Four 8-bit registers, two read ports, one write port;
// a same-cycle write is visible on the read ports.
module cpu_wrapper_v3_register_file
  import cpu_wrapper_v3_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] ra_addr,
  input  logic [1:0] rb_addr,
  output logic [7:0] ra_data,
  output logic [7:0] rb_data,
  input  logic       we,
  input  logic [1:0] wa,
  input  logic [7:0] wd
);

  logic [7:0] regs [0:3];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        regs[i] <= '0;
      end
      regs[3] <= SP_RESET;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data = (we && wa == ra_addr)
                 ? wd : regs[ra_addr];
  assign rb_data = (we && wa == rb_addr)
                 ? wd : regs[rb_addr];

endmodule

// File: rtl/cpu_wrapper_v3.sv
// Five-stage IF/ID/EX/MEM/WB 8-bit core with unified
// 256-byte code/data memory, forwarding and load-use stall.
module cpu_wrapper_v3
  import cpu_wrapper_v3_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] I_Port,
  input  logic       int_sig,
  output logic [7:0] O_Port
);

  if_id_t  if_id;
  id_ex_t  id_ex;
  id_ex_t  id_ex_d;
  ex_mem_t ex_mem;
  ex_mem_t ex_mem_d;
  mem_wb_t mem_wb;
  mem_wb_t mem_wb_d;

  logic [7:0] pc;
  logic [7:0] vec;
  logic [7:0] step;
  logic [7:0] fetch_b0;
  logic [7:0] fetch_b1;
  logic [7:0] ld_data;
  logic       st_we;
  logic [7:0] rf_a;
  logic [7:0] rf_b;
  logic [7:0] fa;
  logic [7:0] fb;
  logic       ex_wen;
  logic       stall;
  logic [7:0] id_instr;
  kind_e      id_kind;
  logic       unused_int;

  assign unused_int = int_sig;

  if (1'b1) begin : mem_inst
    logic [7:0] mem [0:255];

    always_ff @(posedge clk) begin
      if (rstn && st_we) begin
        mem[ex_mem.addr] <= ex_mem.res;
      end
    end

    assign fetch_b0 = mem[pc];
    assign fetch_b1 = mem[pc + 8'd1];
    assign ld_data  = mem[ex_mem.addr];
    assign vec      = mem[8'h00];
  end

  assign step = (fetch_b0[7:4] == OP_MEM)
              ? 8'd2 : 8'd1;

  if (1'b1) begin : PC
    logic [7:0] pc_current;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        pc_current <= vec;
      end else if (!stall) begin
        pc_current <= pc_current + step;
      end
    end

    assign pc = pc_current;
  end

  assign id_instr = if_id.instr;
  assign id_kind  = decode(id_instr);

  cpu_wrapper_v3_register_file regfile_inst (
    .clk     (clk),
    .rstn    (rstn),
    .ra_addr (id_instr[3:2]),
    .rb_addr (id_instr[1:0]),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .we      (mem_wb.wen),
    .wa      (mem_wb.rd),
    .wd      (mem_wb.res)
  );

  // LDD/IN dest is rb; hold ID one cycle for a real use of it.
  assign stall = is_load(id_ex.kind) &&
    ((uses_ra(id_kind) && id_instr[3:2] == id_ex.rb) ||
     (uses_rb(id_kind) && id_instr[1:0] == id_ex.rb));

  always_comb begin
    id_ex_d = '0;
    if (!stall) begin
      id_ex_d.kind = id_kind;
      id_ex_d.ra   = id_instr[3:2];
      id_ex_d.rb   = id_instr[1:0];
      id_ex_d.a    = rf_a;
      id_ex_d.b    = rf_b;
      id_ex_d.imm  = if_id.imm;
    end
  end

  assign ex_wen = writes_reg(ex_mem.kind);

  // EX/MEM checked last so the younger result wins.
  always_comb begin
    fa = id_ex.a;
    fb = id_ex.b;
    if (mem_wb.wen && mem_wb.rd == id_ex.ra) fa = mem_wb.res;
    if (mem_wb.wen && mem_wb.rd == id_ex.rb) fb = mem_wb.res;
    if (ex_wen && ex_mem.rd == id_ex.ra) fa = ex_mem.res;
    if (ex_wen && ex_mem.rd == id_ex.rb) fb = ex_mem.res;
  end

  always_comb begin
    ex_mem_d      = '0;
    ex_mem_d.kind = id_ex.kind;
    ex_mem_d.rd   = dest_reg(id_ex.kind, id_ex.ra, id_ex.rb);
    ex_mem_d.addr = id_ex.imm;
    case (id_ex.kind)
      K_MOV:        ex_mem_d.res = fb;
      K_ADD:        ex_mem_d.res = fa + fb;
      K_SUB:        ex_mem_d.res = fa - fb;
      K_AND:        ex_mem_d.res = fa & fb;
      K_OR:         ex_mem_d.res = fa | fb;
      K_OUT, K_STD: ex_mem_d.res = fb;
      K_LDM:        ex_mem_d.res = id_ex.imm;
      default:      ex_mem_d.res = '0;
    endcase
  end

  assign st_we = (ex_mem.kind == K_STD);

  always_comb begin
    mem_wb_d     = '0;
    mem_wb_d.wen = ex_wen;
    mem_wb_d.rd  = ex_mem.rd;
    unique case (1'b1)
      ex_mem.kind == K_LDD: mem_wb_d.res = ld_data;
      ex_mem.kind == K_IN:  mem_wb_d.res = I_Port;
      default:              mem_wb_d.res = ex_mem.res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      if_id  <= '{instr: NOP_INSTR, imm: 8'h00};
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
      O_Port <= '0;
    end else begin
      if (!stall) begin
        if_id <= '{instr: fetch_b0, imm: fetch_b1};
      end
      id_ex  <= id_ex_d;
      ex_mem <= ex_mem_d;
      mem_wb <= mem_wb_d;
      if (ex_mem.kind == K_OUT) begin
        O_Port <= ex_mem.res;
      end
    end
  end

endmodule

// File: tb/tb_cpu_wrapper_v3.sv
// Bench for cpu_wrapper_v3: directed programs plus random
// programs checked against an instruction-level model.
module tb_cpu_wrapper_v3;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] I_Port;
  logic       int_sig;
  logic [7:0] O_Port;

  always #5 clk = ~clk;

  cpu_wrapper_v3 dut (
    .clk     (clk),
    .rstn    (rstn),
    .I_Port  (I_Port),
    .int_sig (int_sig),
    .O_Port  (O_Port)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m [0:255];
  logic [7:0] r [0:3];
  logic [7:0] exp_q [$];
  bit         chk_on = 1'b0;

  function automatic logic [7:0] rg(input int i);
    return dut.regfile_inst.regs[i];
  endfunction

  task automatic check8(input string name,
                        input logic [7:0] act,
                        input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %02h, want %02h",
               name, act, req);
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < 256; i++) m[i] = 8'h00;
    m[0] = 8'h10;
  endtask

  task automatic load_image();
    for (int i = 0; i < 256; i++) begin
      dut.mem_inst.mem[i] <= m[i];
    end
  endtask

  // Returns at the negedge where rstn has just been released.
  task automatic reset_dut();
    @(negedge clk);
    rstn = 1'b0;
    load_image();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic reset_model(input logic [7:0] r3);
    r[0] = 8'h00;
    r[1] = 8'h00;
    r[2] = 8'h00;
    r[3] = r3;
  endtask

  // Instruction-level interpreter; O_Port history is deduped.
  task automatic model_run(input int n,
                           input logic [7:0] iport);
    logic [7:0] pc;
    logic [7:0] op;
    logic [7:0] b1;
    logic [1:0] a;
    logic [1:0] b;
    pc = m[0];
    exp_q.delete();
    exp_q.push_back(8'h00);
    for (int k = 0; k < n; k++) begin
      op = m[pc];
      b1 = m[pc + 8'd1];
      a  = op[3:2];
      b  = op[1:0];
      case (op[7:4])
        4'h1: r[a] = r[b];
        4'h2: r[a] = r[a] + r[b];
        4'h3: r[a] = r[a] - r[b];
        4'h4: r[a] = r[a] & r[b];
        4'h5: r[a] = r[a] | r[b];
        4'h7: begin
          if (a == 2'b10 && r[b] != exp_q[$])
            exp_q.push_back(r[b]);
          if (a == 2'b11) r[b] = iport;
        end
        4'hC: begin
          if (a == 2'b00) r[b] = b1;
          if (a == 2'b01) r[b] = m[b1];
          if (a == 2'b10) m[b1] = r[b];
        end
        default: ;
      endcase
      pc = pc + ((op[7:4] == 4'hC) ? 8'd2 : 8'd1);
    end
  endtask

  task automatic first_edge(input string name,
                            input int idx,
                            input logic [7:0] val,
                            input int want);
    int e;
    e = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rg(idx) === val) begin
        e = k;
        break;
      end
    end
    vectors++;
    if (e != want) begin
      miscompares++;
      $display("FAIL %s: R%0d=%02h after %0d edges, want %0d",
               name, idx, val, e, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (O_Port !== exp_q[0]) begin
        if (exp_q.size() > 1 && O_Port === exp_q[1]) begin
          void'(exp_q.pop_front());
        end else begin
          miscompares++;
          $display("FAIL oport_seq: got %02h, want %02h",
                   O_Port, exp_q[0]);
        end
      end
    end
  end

  task automatic random_run(input int id);
    logic [3:0] ops [10];
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] iport;
    int n;
    ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
            4'h7, 4'h7, 4'hC, 4'hC, 4'hC};
    clear_image();
    for (int i = 8'h80; i < 8'hC0; i++) m[i] = 8'($urandom);
    n = $urandom_range(8, 20);
    a = 8'h10;
    for (int k = 0; k < n; k++) begin
      op = {ops[$urandom_range(0, 9)], 4'($urandom)};
      if ($urandom_range(0, 7) == 0) op = 8'($urandom);
      m[a] = op;
      if (op[7:4] == 4'hC) begin
        m[a + 8'd1] = {2'b10, 6'($urandom)};
        a = a + 8'd2;
      end else begin
        a = a + 8'd1;
      end
    end
    iport   = 8'($urandom);
    I_Port  = iport;
    int_sig = 1'($urandom);
    reset_dut();
    reset_model(8'hFF);
    model_run(n, iport);
    chk_on = 1'b1;
    repeat (70) @(negedge clk);
    chk_on = 1'b0;
    for (int i = 0; i < 4; i++)
      check8($sformatf("rnd%0d_r%0d", id, i), rg(i), r[i]);
    for (int i = 8'h80; i < 8'hC0; i++)
      check8($sformatf("rnd%0d_mem%02h", id, i),
             dut.mem_inst.mem[i], m[i]);
    vectors++;
    if (exp_q.size() != 1) begin
      miscompares++;
      $display("FAIL rnd%0d_oport_left: %0d pending, want 0",
               id, exp_q.size() - 1);
    end
  endtask

  task automatic ldd_add_image();
    clear_image();
    m[8'h30] = 8'd10;
    m[8'h31] = 8'd20;
    m[8'h10] = 8'hC5;
    m[8'h11] = 8'h30;
    m[8'h12] = 8'hC6;
    m[8'h13] = 8'h31;
    m[8'h14] = 8'h27;
  endtask

  initial begin
    rstn    = 1'b0;
    I_Port  = 8'h00;
    int_sig = 1'b0;

    clear_image();
    reset_dut();
    check8("pc_vec", dut.PC.pc_current, 8'h10);
    check8("oport_rst", O_Port, 8'h00);
    check8("r0_rst", rg(0), 8'h00);
    check8("r2_rst", rg(2), 8'h00);
    check8("r3_rst", rg(3), 8'hFF);
    @(negedge clk);
    check8("pc_step1", dut.PC.pc_current, 8'h11);
    @(negedge clk);
    check8("pc_step2", dut.PC.pc_current, 8'h12);

    ldd_add_image();
    reset_dut();
    dut.regfile_inst.regs[3] <= 8'd5;
    reset_model(8'd5);
    model_run(3, 8'h00);
    check8("model_ldd_add", r[1], 8'd15);
    repeat (30) @(negedge clk);
    check8("ldd_add_r1", rg(1), 8'd15);
    check8("ldd_add_r2", rg(2), r[2]);
    check8("ldd_add_r3", rg(3), 8'd5);

    clear_image();
    m[8'h40] = 8'd3;
    m[8'h10] = 8'hC1;
    m[8'h11] = 8'h07;
    m[8'h12] = 8'hC6;
    m[8'h13] = 8'h40;
    m[8'h14] = 8'h26;
    reset_dut();
    reset_model(8'hFF);
    model_run(3, 8'h00);
    check8("model_stall", r[1], 8'd10);
    first_edge("stall_edge", 1, 8'd10, 8);
    repeat (4) @(negedge clk);
    check8("stall_r1", rg(1), r[1]);
    check8("stall_r2", rg(2), 8'd3);

    clear_image();
    m[8'h10] = 8'hC1;
    m[8'h11] = 8'h01;
    m[8'h12] = 8'h25;
    m[8'h13] = 8'h25;
    reset_dut();
    reset_model(8'hFF);
    model_run(3, 8'h00);
    check8("model_fwd", r[1], 8'd4);
    first_edge("fwd_edge", 1, 8'd4, 7);
    repeat (4) @(negedge clk);
    check8("fwd_r1", rg(1), 8'd4);

    clear_image();
    m[8'h10] = 8'h7E;
    m[8'h11] = 8'h7A;
    m[8'h12] = 8'hCA;
    m[8'h13] = 8'h50;
    I_Port = 8'hA5;
    reset_dut();
    reset_model(8'hFF);
    model_run(3, 8'hA5);
    check8("model_std", m[8'h50], 8'hA5);
    repeat (20) @(negedge clk);
    check8("io_oport", O_Port, 8'hA5);
    check8("io_r2", rg(2), 8'hA5);
    check8("io_mem50", dut.mem_inst.mem[8'h50], 8'hA5);

    ldd_add_image();
    reset_dut();
    dut.regfile_inst.regs[3] <= 8'd5;
    repeat (6) @(negedge clk);
    check8("mid_pre_r1", rg(1), 8'd10);
    rstn = 1'b0;
    @(negedge clk);
    check8("mid_r0", rg(0), 8'h00);
    check8("mid_r1", rg(1), 8'h00);
    check8("mid_r2", rg(2), 8'h00);
    check8("mid_r3", rg(3), 8'hFF);
    check8("mid_oport", O_Port, 8'h00);
    check8("mid_pc", dut.PC.pc_current, 8'h10);
    check8("mid_mem30", dut.mem_inst.mem[8'h30], 8'd10);
    rstn = 1'b1;
    dut.regfile_inst.regs[3] <= 8'd5;
    repeat (30) @(negedge clk);
    check8("rerun_r1", rg(1), 8'd15);
    check8("rerun_r2", rg(2), 8'd20);
    check8("rerun_r3", rg(3), 8'd5);

    for (int t = 0; t < 30; t++) random_run(t);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
